clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Timebase and time-set sequencer for the seven-segment digital clock.
- Divides `clk` down to 1 Hz, keeps the seconds count and issues one-cycle increment pulses to the minutes and hours counters.
- Runs a RUN / SET_H / SET_M state machine driven by two debounced push-buttons, with blink-blank outputs for the display driver.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; one second = CLK_HZ cycles.
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button level must stay stable before it is accepted.
- BLINK_HZ, 2, blink rate of the field being set; half-period = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
- btn_up  input  1  raw increment button, active-high, asynchronous to clk.
- minutes_in  input  6  current minutes value (0..59) from the minutes counter.
- inc_minutes  output  1  one-cycle high pulse; minutes counter advances on its falling edge.
- inc_hours  output  1  one-cycle high pulse; hours counter advances on its falling edge.
- seconds  output  6  current seconds, 0..59.
- mode  output  2  0 = RUN, 1 = SET_H, 2 = SET_M.
- blank_hours  output  1  high = display blanks the hours digits.
- blank_minutes  output  1  high = display blanks the minutes digits.

Behaviour:
- Reset (reset_n low, async):
  - state RUN; seconds = 0; prescaler, blink and debounce counters = 0.
  - Synchronizers and debounced levels = 0 (released).
  - All outputs 0. Release is synchronous to clk.
- Button path, per button:
  - 2-flop synchronizer, then a debounce counter that reloads on any level change and accepts the new level after DEBOUNCE_CYCLES stable cycles.
  - A 0→1 transition of the accepted level produces a one-cycle press pulse.
  - Press-pulse latency from a stable raw edge is DEBOUNCE_CYCLES+3 cycles.
- FSM on mode press: RUN→SET_H→SET_M→RUN. mode output is registered and updates in the cycle after the press pulse.
- Entering SET_H from RUN: seconds and prescaler clear to 0 in the same cycle.
- In SET_H/SET_M: prescaler and seconds are frozen.
- RUN:
  - Prescaler counts 0..CLK_HZ-1; at terminal count, seconds increments.
  - seconds 59→0 wrap asserts inc_minutes for exactly one cycle.
  - If minutes_in==59 in that same cycle, inc_hours is also asserted in the same cycle.
  - btn_up presses are ignored.
- SET_H: each up press yields a one-cycle inc_hours pulse the cycle after the press pulse. No effect on minutes.
- SET_M: each up press yields a one-cycle inc_minutes pulse only. Never an hours carry, even at minutes_in==59.
- Simultaneous mode and up press pulses in the same cycle: mode transition taken, up press discarded, no inc pulse.
- Blink:
  - Counter runs only in SET states and toggles a phase bit every half-period.
  - blank_hours = phase in SET_H; blank_minutes = phase in SET_M.
  - Both are 0 in RUN; phase clears on every state change.
- Increment pulses are never asserted on two consecutive cycles, so the downstream negedge counters always see a full high/low pair.
- Reset mid-debounce or mid-second: all partial counts are discarded and no pulse is emitted on reset release.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- When defined, adds parameters REPEAT_DELAY (default CLK_HZ/2) and REPEAT_PERIOD (default CLK_HZ/8).
  - In SET states, holding the debounced btn_up level high for REPEAT_DELAY cycles after its press generates an extra up press.
  - Further up presses then follow every REPEAT_PERIOD cycles while the button is held.
  - Release or a state change stops repeat immediately.
- When undefined, one inc pulse per physical press only, and the repeat counters are absent.

Test Plan (CLK_HZ=10, DEBOUNCE_CYCLES=4, BLINK_HZ=1):
- Reset, run 600 cycles with minutes_in=5 → seconds counts 0..59 and wraps once; exactly one inc_minutes pulse at cycle 600 of the count; inc_hours stays 0.
- minutes_in=59, run to a seconds wrap → inc_minutes and inc_hours both high in the same single cycle.
- Clean btn_mode press → mode=1 after DEBOUNCE_CYCLES+4 cycles; seconds forced to 0; blank_hours toggles every 5 cycles; three up presses → exactly three inc_hours pulses, no inc_minutes.
- Second mode press → mode=2, blank_hours=0; up press with minutes_in=59 → inc_minutes only. Third press → mode=0, seconds resumes from 0.
- btn_up bouncing 0/1 every 2 cycles for 20 cycles, then stable high → exactly one press; a 3-cycle glitch → no press.
- Mode and up press pulses aligned in the same cycle → state advances, no inc pulse. reset_n low mid-second → seconds=0 and outputs 0 immediately, no pulse on release.

Source files
------------

// File: rtl/clock_set_controller.sv
// Timebase and RUN / SET_H / SET_M time-set sequencer for the seven-segment clock.
// Optional button auto-repeat in the set states is enabled with `define AUTO_REPEAT_EN.
module clock_set_controller #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HZ        = 2
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = CLK_HZ / 2,
  parameter int unsigned REPEAT_PERIOD   = CLK_HZ / 8
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic [5:0] minutes_in,
  output logic       inc_minutes,
  output logic       inc_hours,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blank_hours,
  output logic       blank_minutes
);

  localparam int unsigned PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_MAX   = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned DB_W     = (DB_MAX > 0) ? $clog2(DB_MAX + 1) : 1;
  localparam int unsigned HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam int unsigned BLINK_W  = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t               state;
  logic [PRESC_W-1:0]   presc;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 phase;

  logic [1:0]           raw;
  logic [1:0]           sync1;
  logic [1:0]           sync2;
  logic [1:0]           level;
  logic [1:0]           level_d;
  logic [1:0]           press;
  logic [DB_W-1:0]      db_cnt [2];

  logic                 mode_press_c;
  logic                 up_press_c;
  logic                 up_evt_c;
  logic                 pulse_busy_c;

  // Bit 0 is the mode button, bit 1 the up button.
  assign raw          = {btn_up, btn_mode};
  assign mode_press_c = press[0];
  assign up_press_c   = press[1];
  assign pulse_busy_c = inc_minutes | inc_hours;
  assign mode         = state;

  // Synchronize, debounce and edge-detect both buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_d   <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_MAX)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_hold_c;
  logic             rpt_fire_c;

  assign rpt_hold_c = level[1] && (state != RUN) && !mode_press_c && !up_press_c;
  assign rpt_fire_c = rpt_hold_c &&
                      (rpt_cnt == (rpt_armed ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1)));
  assign up_evt_c   = up_press_c | rpt_fire_c;

  // Held up button: first repeat after the delay, then one per period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!rpt_hold_c) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire_c) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign up_evt_c = up_press_c;
`endif

  // Mode sequencing, seconds timebase and increment pulses; a mode press outranks everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      presc       <= '0;
      seconds     <= '0;
      inc_minutes <= 1'b0;
      inc_hours   <= 1'b0;
    end else begin
      inc_minutes <= 1'b0;
      inc_hours   <= 1'b0;
      if (mode_press_c) begin
        case (state)
          RUN: begin
            state   <= SET_H;
            presc   <= '0;
            seconds <= '0;
          end
          SET_H:   state <= SET_M;
          default: state <= RUN;
        endcase
      end else begin
        case (state)
          RUN: begin
            if (presc == PRESC_W'(CLK_HZ - 1)) begin
              presc <= '0;
              if (seconds == 6'd59) begin
                seconds     <= '0;
                inc_minutes <= 1'b1;
                inc_hours   <= (minutes_in == 6'd59);
              end else begin
                seconds <= seconds + 6'd1;
              end
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          SET_H: begin
            if (up_evt_c && !pulse_busy_c) inc_hours <= 1'b1;
          end
          SET_M: begin
            if (up_evt_c && !pulse_busy_c) inc_minutes <= 1'b1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  // Blink phase for the field being set; restarts blanked-off on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt     <= '0;
      phase         <= 1'b0;
      blank_hours   <= 1'b0;
      blank_minutes <= 1'b0;
    end else if (mode_press_c || state == RUN) begin
      blink_cnt     <= '0;
      phase         <= 1'b0;
      blank_hours   <= 1'b0;
      blank_minutes <= 1'b0;
    end else if (blink_cnt == BLINK_W'(HALF - 1)) begin
      blink_cnt     <= '0;
      phase         <= ~phase;
      blank_hours   <= (state == SET_H) && !phase;
      blank_minutes <= (state == SET_M) && !phase;
    end else begin
      blink_cnt     <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed/randomized bench for clock_set_controller with a wall-clock style reference model.
module tb_clock_set_controller;

  localparam int unsigned CLK_HZ   = 10;
  localparam int unsigned DB       = 4;
  localparam int unsigned BLINK_HZ = 1;
  localparam int unsigned HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned MIN_CYC  = CLK_HZ * 60;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_up;
  logic [5:0] minutes_in;
  logic       inc_minutes;
  logic       inc_hours;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blank_hours;
  logic       blank_minutes;

  int   checks   = 0;
  int   failures = 0;
  int   n_min    = 0;
  int   n_hr     = 0;
  int   consec   = 0;
  logic prev_inc = 1'b0;
  bit   chk_run  = 1'b0;
  int   run_n    = 0;

  always #5 clk = ~clk;

  clock_set_controller #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DB),
    .BLINK_HZ        (BLINK_HZ)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .minutes_in    (minutes_in),
    .inc_minutes   (inc_minutes),
    .inc_hours     (inc_hours),
    .seconds       (seconds),
    .mode          (mode),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; the RUN model says seconds = elapsed RUN cycles / CLK_HZ mod 60 and a minute carry every 600.
  task automatic step();
    logic [5:0] m_at_edge;
    bit         wrap;
    m_at_edge = minutes_in;
    @(negedge clk);
    if (inc_minutes === 1'b1) n_min++;
    if (inc_hours === 1'b1) n_hr++;
    if ((inc_minutes === 1'b1 || inc_hours === 1'b1) && prev_inc) consec++;
    prev_inc = (inc_minutes === 1'b1 || inc_hours === 1'b1);
    if (chk_run) begin
      run_n++;
      wrap = (run_n % MIN_CYC) == 0;
      check("run_seconds", 32'(seconds), 32'((run_n / CLK_HZ) % 60));
      check("run_inc_minutes", 32'(inc_minutes), 32'(wrap));
      check("run_inc_hours", 32'(inc_hours), 32'(wrap && m_at_edge == 6'd59));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_seconds"}, 32'(seconds), 32'(0));
    check({tag, "_mode"}, 32'(mode), 32'(0));
    check({tag, "_inc_minutes"}, 32'(inc_minutes), 32'(0));
    check({tag, "_inc_hours"}, 32'(inc_hours), 32'(0));
    check({tag, "_blank_hours"}, 32'(blank_hours), 32'(0));
    check({tag, "_blank_minutes"}, 32'(blank_minutes), 32'(0));
  endtask

  // Clean mode press (optionally with a simultaneous up press); mode must change exactly DB+4 cycles later.
  task automatic press_mode(input logic [1:0] cur, input logic [1:0] nxt, input bit with_up);
    int b_min;
    int b_hr;
    b_min = n_min;
    b_hr  = n_hr;
    btn_mode = 1'b1;
    if (with_up) btn_up = 1'b1;
    for (int i = 1; i <= int'(DB) + 3; i++) step();
    check("mode_before_change", 32'(mode), 32'(cur));
    chk_run = 1'b0;
    step();
    check("mode_after_change", 32'(mode), 32'(nxt));
    check("seconds_on_change", 32'(seconds), 32'(0));
    check("no_inc_min_on_change", 32'(inc_minutes), 32'(0));
    check("no_inc_hr_on_change", 32'(inc_hours), 32'(0));
    if (nxt == 2'd0) begin
      run_n   = 0;
      chk_run = 1'b1;
    end
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("blank_hours", 32'(blank_hours), 32'(nxt == 2'd1 && ((i / int'(HALF)) % 2) == 1));
      check("blank_minutes", 32'(blank_minutes), 32'(nxt == 2'd2 && ((i / int'(HALF)) % 2) == 1));
    end
    if (cur != 2'd0) begin
      check("mode_press_min_count", 32'(n_min - b_min), 32'(0));
      check("mode_press_hr_count", 32'(n_hr - b_hr), 32'(0));
    end
  endtask

  // Clean up press in a set state; the increment pulse lands exactly DB+4 cycles after the raw edge.
  task automatic press_up(input bit exp_hr, input bit exp_min);
    btn_up = 1'b1;
    for (int i = 1; i <= int'(DB) + 6; i++) begin
      step();
      check("up_inc_hours", 32'(inc_hours), 32'(i == int'(DB) + 4 && exp_hr));
      check("up_inc_minutes", 32'(inc_minutes), 32'(i == int'(DB) + 4 && exp_min));
    end
    btn_up = 1'b0;
    for (int i = 1; i <= int'(DB) + 6; i++) begin
      step();
      check("release_inc_hours", 32'(inc_hours), 32'(0));
      check("release_inc_minutes", 32'(inc_minutes), 32'(0));
    end
  endtask

  initial begin
    int b_min;
    int b_hr;
    int tot;
    int h;
    bit val;

    reset_n    = 1'b0;
    btn_mode   = 1'b0;
    btn_up     = 1'b0;
    minutes_in = 6'd5;
    repeat (3) step();
    check_idle_outputs("reset");

    // One full minute with minutes_in=5, then a minute ending at minutes_in=59.
    reset_n = 1'b1;
    run_n   = 0;
    chk_run = 1'b1;
    repeat (int'(MIN_CYC)) step();
    check("first_minute_inc_minutes", 32'(n_min), 32'(1));
    check("first_minute_inc_hours", 32'(n_hr), 32'(0));
    minutes_in = 6'd59;
    repeat (int'(MIN_CYC)) step();
    check("carry_inc_minutes", 32'(n_min), 32'(2));
    check("carry_inc_hours", 32'(n_hr), 32'(1));

    minutes_in = 6'($urandom_range(0, 58));
    repeat ($urandom_range(12, 37)) step();
    press_mode(2'd0, 2'd1, 1'b0);

    // SET_H: three up presses give three hour pulses and nothing else.
    b_min = n_min;
    b_hr  = n_hr;
    for (int k = 0; k < 3; k++) begin
      minutes_in = 6'($urandom_range(0, 59));
      press_up(1'b1, 1'b0);
    end
    check("set_h_hour_pulses", 32'(n_hr - b_hr), 32'(3));
    check("set_h_minute_pulses", 32'(n_min - b_min), 32'(0));
    check("set_h_seconds_frozen", 32'(seconds), 32'(0));

    press_mode(2'd1, 2'd2, 1'b0);

    // SET_M at minutes_in=59: minutes pulse only, never an hours carry.
    minutes_in = 6'd59;
    press_up(1'b0, 1'b1);

    // Bouncing contact settles into one press; a short glitch gives none.
    b_min = n_min;
    b_hr  = n_hr;
    tot   = 0;
    val   = 1'b1;
    while (tot < 20) begin
      btn_up = val;
      h = int'($urandom_range(1, DB - 1));
      repeat (h) step();
      tot += h;
      val = ~val;
    end
    btn_up = 1'b1;
    repeat (DB + 6) step();
    btn_up = 1'b0;
    repeat (DB + 6) step();
    check("bounce_one_press", 32'(n_min - b_min), 32'(1));
    check("bounce_no_hours", 32'(n_hr - b_hr), 32'(0));
    b_min  = n_min;
    btn_up = 1'b1;
    repeat ($urandom_range(1, DB - 1)) step();
    btn_up = 1'b0;
    repeat (DB + 6) step();
    check("glitch_no_press", 32'(n_min - b_min), 32'(0));
    check("set_m_blank_hours_low", 32'(blank_hours), 32'(0));

    // Mode and up pulses coincide: back to RUN, up discarded, seconds restart from 0.
    minutes_in = 6'($urandom_range(0, 58));
    press_mode(2'd2, 2'd0, 1'b1);
    repeat ($urandom_range(40, 200)) step();

    // Asynchronous reset mid-second and mid-debounce.
    btn_mode = 1'b1;
    step();
    step();
    b_min   = n_min;
    b_hr    = n_hr;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    btn_mode = 1'b0;
    chk_run  = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    run_n   = 0;
    chk_run = 1'b1;
    repeat (40) step();
    check("post_reset_mode", 32'(mode), 32'(0));
    check("post_reset_min_pulses", 32'(n_min - b_min), 32'(0));
    check("post_reset_hr_pulses", 32'(n_hr - b_hr), 32'(0));
    check("no_back_to_back_pulses", 32'(consec), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
